// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with registered read data, occupancy and threshold flags
// Ports: clk, reset (async active-low), write_enable/data_in, read_enable/data_out,
//        full, empty, almost_full, almost_empty, count, overflow/underflow (PARAM_FIFO_ERR_EN only).
// Macro PARAM_FIFO_ERR_EN adds sticky overflow/underflow error flags.
module param_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count
`ifdef PARAM_FIFO_ERR_EN
  ,
  output logic                    overflow,
  output logic                    underflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_rd_ok, w_wr_ok;
  assign w_rd_ok      = read_enable && !empty;
  assign w_wr_ok      = write_enable && (!full || w_rd_ok);
  assign empty        = r_count == '0;
  assign full         = r_count == CW'(DEPTH);
  assign almost_full  = r_count >= CW'(ALMOST_FULL_THRESH);
  assign almost_empty = r_count <= CW'(ALMOST_EMPTY_THRESH);
  assign count        = r_count;
  assign data_out     = r_data_out;
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= data_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) begin
        r_rptr     <= r_rptr + 1'b1;
        r_data_out <= r_mem[r_rptr];
      end
      if (w_wr_ok != w_rd_ok) r_count <= w_wr_ok ? r_count + 1'b1 : r_count - 1'b1;
    end
  end
`ifdef PARAM_FIFO_ERR_EN
  logic r_overflow, r_underflow;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && !w_wr_ok) r_overflow <= 1'b1;
      if (read_enable && !w_rd_ok) r_underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo at DEPTH=4, AF=3, AE=1
module tb_param_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enable = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
`ifdef PARAM_FIFO_ERR_EN
  logic       overflow, underflow;
`endif
  int checks = 0;
  int errors = 0;
  param_fifo #(
    .DATA_WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESH(3), .ALMOST_EMPTY_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .data_in(data_in),
    .read_enable(read_enable), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count)
`ifdef PARAM_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    write_enable = we;
    data_in      = d;
    read_enable  = re;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask
  task automatic fill();
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(1, 8'h44, 0);
  endtask
  task automatic test_reset();
    logic [7:0] exp_data [4];
    exp_data = '{8'h77, 8'h88, 8'h99, 8'hAA};
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    checks++;
    if (data_out !== 8'h77) begin errors++; $display("FAIL reset_pre data_out got %h want 77", data_out); end
    step(1, exp_data[1], 0);
    step(1, exp_data[2], 0);
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_in      = exp_data[3];
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({count, empty, full, almost_empty, almost_full} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags got count=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0", count, empty, full, almost_empty, almost_full);
    end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
`ifdef PARAM_FIFO_ERR_EN
    checks++;
    if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
`endif
    write_enable = 1'b0;
    read_enable  = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL reset_hold got count=%0d empty=%b want 0 1", count, empty); end
  endtask
  task automatic test_fill_drain();
    logic [7:0] exp_data [4];
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1, exp_data[i], 0);
      checks++;
      if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      checks++;
      if (almost_full !== (i >= 2) || full !== (i == 3) || almost_empty !== (i == 0) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags[%0d] got af=%b f=%b ae=%b e=%b", i, almost_full, full, almost_empty, empty);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1);
      checks++;
      if (data_out !== exp_data[i]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, data_out, exp_data[i]); end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got e=%b count=%0d want 1 0", empty, count); end
  endtask
  task automatic test_overflow();
    logic [7:0] exp_data [4];
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill();
    step(1, 8'h55, 0);
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d full=%b want 4 1", count, full); end
`ifdef PARAM_FIFO_ERR_EN
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1);
      checks++;
      if (data_out !== exp_data[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, data_out, exp_data[i]); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", empty); end
`ifdef PARAM_FIFO_ERR_EN
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_sticky got ovf=%b unf=%b want 1 0", overflow, underflow); end
`endif
  endtask
  task automatic test_full_rw();
    logic [7:0] exp_data [4];
    exp_data = '{8'h22, 8'h33, 8'h44, 8'h55};
    fill();
    step(1, 8'h55, 1);
    checks++;
    if (data_out !== 8'h11) begin errors++; $display("FAIL full_rw_data got %h want 11", data_out); end
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_rw_count got %0d full=%b want 4 1", count, full); end
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1);
      checks++;
      if (data_out !== exp_data[i]) begin errors++; $display("FAIL full_rw_tail[%0d] got %h want %h", i, data_out, exp_data[i]); end
    end
  endtask
  task automatic test_empty_rw();
    step(1, 8'hA5, 1);
    checks++;
    if (count !== 3'd1 || empty !== 1'b0) begin errors++; $display("FAIL empty_rw_count got %0d empty=%b want 1 0", count, empty); end
    checks++;
    if (data_out !== 8'h55) begin errors++; $display("FAIL empty_rw_data got %h want 55", data_out); end
`ifdef PARAM_FIFO_ERR_EN
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_unf got %b want 1", underflow); end
`endif
    step(0, 8'h00, 1);
    checks++;
    if (data_out !== 8'hA5 || count !== 3'd0) begin errors++; $display("FAIL empty_rw_read got %h count=%0d want a5 0", data_out, count); end
  endtask
  task automatic test_wrap();
    logic [7:0] wv, rv;
    wv = 8'h01;
    rv = 8'h01;
    for (int lap = 0; lap < 10; lap++) begin
      for (int i = 0; i < 3; i++) begin
        step(1, wv, 0);
        wv++;
        checks++;
        if (count > 3'd3 || count !== 3'(i + 1)) begin errors++; $display("FAIL wrap_count[%0d.%0d] got %0d want %0d", lap, i, count, i + 1); end
      end
      for (int i = 0; i < 3; i++) begin
        step(0, 8'h00, 1);
        checks++;
        if (data_out !== rv) begin errors++; $display("FAIL wrap_data[%0d.%0d] got %h want %h", lap, i, data_out, rv); end
        rv++;
      end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask
  task automatic test_idle_read();
    step(0, 8'h00, 1);
    checks++;
    if (data_out !== 8'h1E || count !== 3'd0) begin errors++; $display("FAIL idle_read got %h count=%0d want 1e 0", data_out, count); end
  endtask
  initial begin
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_idle_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
